pc_sequencer: RTL and testbench

Parametrised program-counter unit for the fetch stage, successor to the single-jump PC register. It holds the architectural PC and selects each cycle between sequential increment, PC-relative branch, absolute jump, and subroutine return. Returns are served by an internal circular return-address stack (RAS). The block has stall support, a configurable reset vector, and sticky stack-error flags.

---
 rtl/pc_sequencer.sv | 139 +++++++++++++
 tb/tb_pc_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with a circular return-address stack (RAS).
// Optional target alignment checking is enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned       RAS_DEPTH    = 4,
  localparam int unsigned      PW           = $clog2(RAS_DEPTH),
  localparam int unsigned      CW           = PW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump_enable,
  input  logic [WIDTH-1:0] jump_address,
  input  logic             call,
  input  logic             return_enable,
  output logic [WIDTH-1:0] pc_value,
  output logic [WIDTH-1:0] pc_next,
  output logic [CW-1:0]    ras_count,
  output logic             ras_overflow,
  output logic             ras_underflow,
  output logic             misalign_fault
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;

  logic [WIDTH-1:0] seq;
  logic [WIDTH-1:0] target;
  logic             ras_empty;
  logic             ras_full;
  logic             misaligned;
  logic             advance;
`ifdef PC_ALIGN_CHECK_EN
  logic             redirect;
`endif

  always_comb begin
    seq       = pc_q + WIDTH'(4);
    ras_empty = (count_q == '0);
    ras_full  = (count_q == CW'(RAS_DEPTH));

    // An empty-stack return falls through to the sequential address.
    if (return_enable)
      target = ras_empty ? seq : ras_q[top_q];
    else if (jump_enable)
      target = jump_address;
    else if (branch_taken)
      target = pc_q + branch_offset;
    else
      target = seq;

`ifdef PC_ALIGN_CHECK_EN
    redirect   = return_enable | jump_enable | branch_taken;
    misaligned = redirect & (target[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif

    advance = !stall && !misaligned;
    pc_d    = advance ? target : pc_q;

    top_d   = top_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_idx  = top_q;
    wr_data = seq;

    if (advance) begin
      if (return_enable && jump_enable && call) begin
        // Pop and push cancel: the top slot is simply rewritten in place.
        wr_en = 1'b1;
        if (ras_empty) begin
          count_d = CW'(1);
          unf_d   = 1'b1;
        end
      end else if (return_enable) begin
        if (ras_empty) begin
          unf_d = 1'b1;
        end else begin
          top_d   = top_q - PW'(1);
          count_d = count_q - CW'(1);
        end
      end else if (jump_enable && call) begin
        // A full stack wraps onto its oldest entry.
        wr_en  = 1'b1;
        wr_idx = top_q + PW'(1);
        top_d  = top_q + PW'(1);
        if (ras_full)
          ovf_d = 1'b1;
        else
          count_d = count_q + CW'(1);
      end
    end

    misalign_fault = misaligned && !stall && !reset;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents are meaningless after reset, so the array carries no reset.
  always_ff @(posedge clock) begin
    if (wr_en && !reset)
      ras_q[wr_idx] <= wr_data;
  end

  assign pc_value      = pc_q;
  assign pc_next       = pc_d;
  assign ras_count     = count_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic
// compared against a queue-based return-stack model.
module tb_pc_sequencer;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump_enable;
  logic [31:0] jump_address;
  logic        call;
  logic        return_enable;
  logic [31:0] pc_value;
  logic [31:0] pc_next;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;
  logic        misalign_fault;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ras [$];
  logic        m_ovf;
  logic        m_unf;

  logic [31:0] obs_next, exp_next;
  logic        obs_fault, exp_fault;

  pc_sequencer #(
    .WIDTH(32),
    .RESET_VECTOR(32'h0000_0100),
    .RAS_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_offset(branch_offset),
    .jump_enable(jump_enable),
    .jump_address(jump_address),
    .call(call),
    .return_enable(return_enable),
    .pc_value(pc_value),
    .pc_next(pc_next),
    .ras_count(ras_count),
    .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow),
    .misalign_fault(misalign_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic set_in(input bit st, input bit br, input logic [31:0] off,
                        input bit jm, input logic [31:0] ja, input bit cl, input bit rt);
    stall         = st;
    branch_taken  = br;
    branch_offset = off;
    jump_enable   = jm;
    jump_address  = ja;
    call          = cl;
    return_enable = rt;
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_0100;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Samples combinational outputs mid-cycle, advances the model, crosses one edge.
  task automatic tick();
    logic [31:0] seq, tgt;
    #3;
    obs_next  = pc_next;
    obs_fault = misalign_fault;
    seq       = m_pc + 32'd4;
    exp_fault = 1'b0;
    if (stall) begin
      exp_next = m_pc;
    end else begin
      if (return_enable)     tgt = (m_ras.size() == 0) ? seq : m_ras[$];
      else if (jump_enable)  tgt = jump_address;
      else if (branch_taken) tgt = m_pc + branch_offset;
      else                   tgt = seq;
      exp_next = tgt;
`ifdef PC_ALIGN_CHECK_EN
      if ((return_enable || jump_enable || branch_taken) && tgt[1:0] != 2'b00) begin
        exp_next  = m_pc;
        exp_fault = 1'b1;
      end
`endif
      if (!exp_fault) begin
        if (return_enable) begin
          if (m_ras.size() == 0) m_unf = 1'b1;
          else void'(m_ras.pop_back());
        end
        if (jump_enable && call) begin
          if (m_ras.size() == 4) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_ras.push_back(seq);
        end
        m_pc = tgt;
      end
    end
    @(posedge clock);
    #1;
    $display("txn next=%h pc=%h cnt=%0d ovf=%0b unf=%0b fault=%0b",
             obs_next, pc_value, ras_count, ras_overflow, ras_underflow, obs_fault);
  endtask

  task automatic test_reset();
    set_in(0, 0, 32'h0, 0, 32'h0, 0, 0);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++; if (pc_value !== 32'h100) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc_value, 32'h100); end
    checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", ras_count); end
    checks++; if ({ras_overflow, ras_underflow, misalign_fault} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b exp=000", {ras_overflow, ras_underflow, misalign_fault}); end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (pc_value !== 32'h100 + 32'(4 * k)) begin
        errors++; $display("FAIL seq_pc%0d got=%h exp=%h", k, pc_value, 32'h100 + 32'(4 * k)); end
    end
    checks++; if ({ras_overflow, ras_underflow} !== 2'b00) begin
      errors++; $display("FAIL seq_flags got=%b exp=00", {ras_overflow, ras_underflow}); end
  endtask

  task automatic test_branch_jump();
    set_in(0, 0, 32'h0, 1, 32'h200, 0, 0); tick();
    checks++; if (pc_value !== 32'h200) begin errors++; $display("FAIL jump_200 got=%h exp=200", pc_value); end
    set_in(0, 1, -32'sd8, 0, 32'h0, 0, 0); tick();
    checks++; if (obs_next !== 32'h1F8) begin errors++; $display("FAIL branch_next got=%h exp=1f8", obs_next); end
    checks++; if (pc_value !== 32'h1F8) begin errors++; $display("FAIL branch_back got=%h exp=1f8", pc_value); end
    set_in(0, 1, 32'h40, 1, 32'h400, 0, 0); tick();
    checks++; if (pc_value !== 32'h400) begin errors++; $display("FAIL jump_wins got=%h exp=400", pc_value); end
  endtask

  task automatic test_call_return();
    set_in(0, 0, 32'h0, 1, 32'h10, 0, 0); tick();
    checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL cr_count0 got=%0d exp=0", ras_count); end
    set_in(0, 0, 32'h0, 1, 32'h80, 1, 0); tick();
    checks++; if (pc_value !== 32'h80 || ras_count !== 3'd1) begin
      errors++; $display("FAIL cr_call1 got=%h/%0d exp=80/1", pc_value, ras_count); end
    set_in(0, 0, 32'h0, 1, 32'hC0, 1, 0); tick();
    checks++; if (pc_value !== 32'hC0 || ras_count !== 3'd2) begin
      errors++; $display("FAIL cr_call2 got=%h/%0d exp=c0/2", pc_value, ras_count); end
    set_in(0, 0, 32'h0, 0, 32'h0, 0, 1); tick();
    checks++; if (pc_value !== 32'h84 || ras_count !== 3'd1) begin
      errors++; $display("FAIL cr_ret1 got=%h/%0d exp=84/1", pc_value, ras_count); end
    tick();
    checks++; if (pc_value !== 32'h14 || ras_count !== 3'd0) begin
      errors++; $display("FAIL cr_ret2 got=%h/%0d exp=14/0", pc_value, ras_count); end
    // Call immediately followed by its return.
    set_in(0, 0, 32'h0, 1, 32'h300, 1, 0); tick();
    set_in(0, 0, 32'h0, 0, 32'h0, 0, 1); tick();
    checks++; if (pc_value !== 32'h18 || ras_count !== 3'd0) begin
      errors++; $display("FAIL b2b_ret got=%h/%0d exp=18/0", pc_value, ras_count); end
  endtask

  task automatic test_ras_limits();
    logic [31:0] exp_ret;
    set_in(0, 0, 32'h0, 1, 32'h1000, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 32'h0, 1, 32'h2000 + 32'(i) * 32'h1000, 1, 0); tick();
      checks++; if (ras_count !== ((i < 4) ? 3'(i + 1) : 3'd4)) begin
        errors++; $display("FAIL lim_call%0d_count got=%0d", i, ras_count); end
    end
    checks++; if (ras_overflow !== 1'b1) begin errors++; $display("FAIL lim_ovf got=%b exp=1", ras_overflow); end
    for (int i = 0; i < 4; i++) begin
      exp_ret = 32'h5004 - 32'(i) * 32'h1000;
      set_in(0, 0, 32'h0, 0, 32'h0, 0, 1); tick();
      checks++; if (pc_value !== exp_ret || ras_count !== 3'(3 - i)) begin
        errors++; $display("FAIL lim_ret%0d got=%h/%0d exp=%h/%0d", i, pc_value, ras_count, exp_ret, 3 - i); end
    end
    checks++; if (ras_underflow !== 1'b0) begin errors++; $display("FAIL lim_unf_early got=%b exp=0", ras_underflow); end
    tick();
    checks++; if (pc_value !== 32'h2008 || ras_count !== 3'd0 || ras_underflow !== 1'b1) begin
      errors++; $display("FAIL lim_ret5 got=%h/%0d/%b exp=2008/0/1", pc_value, ras_count, ras_underflow); end
  endtask

  task automatic test_stall_reset();
    set_in(1, 0, 32'h0, 1, 32'h600, 1, 0); tick();
    checks++; if (obs_next !== 32'h2008) begin errors++; $display("FAIL stall_next got=%h exp=2008", obs_next); end
    checks++; if (pc_value !== 32'h2008 || ras_count !== 3'd0) begin
      errors++; $display("FAIL stall_hold got=%h/%0d exp=2008/0", pc_value, ras_count); end
    set_in(0, 0, 32'h0, 1, 32'h600, 1, 0); tick();
    checks++; if (pc_value !== 32'h600 || ras_count !== 3'd1) begin
      errors++; $display("FAIL unstall_call got=%h/%0d exp=600/1", pc_value, ras_count); end
    // Reset between edges while a call is being presented.
    set_in(0, 0, 32'h0, 1, 32'h700, 1, 0);
    #2 reset = 1'b1;
    #1;
    checks++; if (pc_value !== 32'h100 || ras_count !== 3'd0) begin
      errors++; $display("FAIL midreset got=%h/%0d exp=100/0", pc_value, ras_count); end
    checks++; if ({ras_overflow, ras_underflow} !== 2'b00) begin
      errors++; $display("FAIL midreset_flags got=%b exp=00", {ras_overflow, ras_underflow}); end
    set_in(0, 0, 32'h0, 0, 32'h0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    tick();
    checks++; if (pc_value !== 32'h104 || ras_count !== 3'd0) begin
      errors++; $display("FAIL postreset got=%h/%0d exp=104/0", pc_value, ras_count); end
  endtask

  task automatic test_misalign();
    set_in(0, 0, 32'h0, 1, 32'h102, 1, 0); tick();
`ifdef PC_ALIGN_CHECK_EN
    checks++; if (obs_fault !== 1'b1) begin errors++; $display("FAIL mis_fault got=%b exp=1", obs_fault); end
    checks++; if (obs_next !== 32'h104) begin errors++; $display("FAIL mis_next got=%h exp=104", obs_next); end
    checks++; if (pc_value !== 32'h104 || ras_count !== 3'd0) begin
      errors++; $display("FAIL mis_hold got=%h/%0d exp=104/0", pc_value, ras_count); end
    set_in(0, 0, 32'h0, 0, 32'h0, 0, 0); tick();
    checks++; if (obs_fault !== 1'b0 || pc_value !== 32'h108) begin
      errors++; $display("FAIL mis_after got=%b/%h exp=0/108", obs_fault, pc_value); end
`else
    checks++; if (obs_fault !== 1'b0) begin errors++; $display("FAIL mis_fault got=%b exp=0", obs_fault); end
    checks++; if (pc_value !== 32'h102 || ras_count !== 3'd1) begin
      errors++; $display("FAIL mis_take got=%h/%0d exp=102/1", pc_value, ras_count); end
`endif
  endtask

  task automatic test_random();
    int r;
    logic [31:0] ja, off;
    for (int i = 0; i < 400; i++) begin
      r   = int'($urandom_range(0, 15));
      ja  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      off = 32'($urandom_range(0, 63)) * 32'd4 - 32'd128;
      if ($urandom_range(0, 7) == 0) ja  = ja | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) off = off | 32'($urandom_range(1, 3));
      set_in($urandom_range(0, 7) == 0, r < 4, off, (r >= 4 && r < 10) || r == 15, ja,
             $urandom_range(0, 1) == 1, r >= 10);
      tick();
      checks++; if (obs_next !== exp_next) begin
        errors++; $display("FAIL rnd%0d_next got=%h exp=%h", i, obs_next, exp_next); end
      checks++; if (obs_fault !== exp_fault) begin
        errors++; $display("FAIL rnd%0d_fault got=%b exp=%b", i, obs_fault, exp_fault); end
      checks++; if (pc_value !== m_pc) begin
        errors++; $display("FAIL rnd%0d_pc got=%h exp=%h", i, pc_value, m_pc); end
      checks++; if (ras_count !== 3'(m_ras.size())) begin
        errors++; $display("FAIL rnd%0d_count got=%0d exp=%0d", i, ras_count, m_ras.size()); end
      checks++; if ({ras_overflow, ras_underflow} !== {m_ovf, m_unf}) begin
        errors++; $display("FAIL rnd%0d_flags got=%b exp=%b", i, {ras_overflow, ras_underflow}, {m_ovf, m_unf}); end
    end
  endtask

  initial begin
    test_reset();
    test_branch_jump();
    test_call_return();
    test_ras_limits();
    test_stall_reset();
    test_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
